// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: bus widths, write-enable encodings and
// FSM state type.
package dmem_responder_pkg;

  localparam int unsigned DATA_BUS     = 32;
  localparam int unsigned MEM_ADDR_BUS = 32;

  localparam logic [3:0]          DMWRITE_DISABLE = 4'b0000;
  localparam logic [DATA_BUS-1:0] DATA_INITIAL    = '0;

  localparam logic [3:0] EN_B0   = 4'b0001;
  localparam logic [3:0] EN_B1   = 4'b0010;
  localparam logic [3:0] EN_B2   = 4'b0100;
  localparam logic [3:0] EN_B3   = 4'b1000;
  localparam logic [3:0] EN_H0   = 4'b0011;
  localparam logic [3:0] EN_H1   = 4'b1100;
  localparam logic [3:0] EN_WORD = 4'b1111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } dmem_state_e;

  // Zero is accepted here: it simply writes nothing and is not an error.
  function automatic logic dwea_ok(logic [3:0] en);
    case (en)
      DMWRITE_DISABLE, EN_B0, EN_B1, EN_B2, EN_B3, EN_H0, EN_H1, EN_WORD: dwea_ok = 1'b1;
      default: dwea_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM with four byte-write enables and a registered read port that
// holds its value between reads.
module dmem_ram
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic [3:0]          we_i,
  input  logic                re_i,
  input  logic [AddrW-1:0]    addr_i,
  input  logic [DATA_BUS-1:0] wdata_i,
  output logic [DATA_BUS-1:0] rdata_o
);

  logic [DATA_BUS-1:0] mem_q [DEPTH];
  logic [DATA_BUS-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data responder: byte-enabled stores, right-aligned loads through a
// synchronous RAM, with a load stall FSM and a sticky illegal-request flag.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned ADDR_W      = MEM_ADDR_BUS,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_w,
  input  logic                mem_r,
  input  logic [3:0]          dwea,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_BUS-1:0] wdata,
  output logic [DATA_BUS-1:0] rdata,
  output logic                stop,
  output logic                err
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

  dmem_state_e         state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [1:0]          off_q, off_d;
  logic [DATA_BUS-1:0] rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [AW-1:0]       word_idx;
  logic [1:0]          byte_off;
  logic [63:0]         wdata_dbl;
  logic [DATA_BUS-1:0] wdata_rot;
  logic [DATA_BUS-1:0] ram_rdata;
  logic [DATA_BUS-1:0] load_data;
  logic [3:0]          ram_we;
  logic                ram_re;
  logic                unused_addr;

  // Upper address bits alias onto the RAM.
  assign word_idx    = addr[AW+1:2];
  assign byte_off    = addr[1:0];
  assign unused_addr = ^addr[ADDR_W-1:AW+2];

  // Rotate store data left so byte k of wdata lands on lane (k + offset) mod 4.
  assign wdata_dbl = {wdata, wdata} << {byte_off, 3'b000};
  assign wdata_rot = wdata_dbl[63:32];
  assign load_data = ram_rdata >> {off_q, 3'b000};

  dmem_ram #(
    .DEPTH (DEPTH),
    .AddrW (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (word_idx),
    .wdata_i (wdata_rot),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ram_we  = DMWRITE_DISABLE;
    ram_re  = 1'b0;
    stop    = 1'b0;
    rdata   = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (mem_w) begin
          // A simultaneous load is dropped; the store still goes through if legal.
          if (dwea_ok(dwea)) begin
            ram_we = dwea;
          end else begin
            err_d = 1'b1;
          end
          if (mem_r) begin
            err_d = 1'b1;
          end
        end else if (mem_r) begin
          ram_re  = 1'b1;
          off_d   = byte_off;
          cnt_d   = WaitInit;
          stop    = 1'b1;
          state_d = (WAIT_STATES > 0) ? StWait : StDone;
        end
      end
      StWait: begin
        stop  = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StDone;
        end
      end
      StDone: begin
        rdata   = load_data;
        rdata_d = load_data;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (rst) begin
      stop   = 1'b0;
      ram_we = DMWRITE_DISABLE;
      ram_re = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      off_q   <= 2'd0;
      rdata_q <= DATA_INITIAL;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 0, 3 and 2 wait states share
// clock and data inputs but have private strobes and resets.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  dwea;

  logic        rst_a, mem_w_a, mem_r_a, stop_a, err_a;
  logic        rst_b, mem_w_b, mem_r_b, stop_b, err_b;
  logic        rst_c, mem_w_c, mem_r_c, stop_c, err_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .ADDR_W(32), .WAIT_STATES(0)) u_a (
    .clk (clk), .rst (rst_a), .mem_w (mem_w_a), .mem_r (mem_r_a), .dwea (dwea),
    .addr (addr), .wdata (wdata), .rdata (rdata_a), .stop (stop_a), .err (err_a)
  );

  dmem_responder #(.DEPTH(1024), .ADDR_W(32), .WAIT_STATES(3)) u_b (
    .clk (clk), .rst (rst_b), .mem_w (mem_w_b), .mem_r (mem_r_b), .dwea (dwea),
    .addr (addr), .wdata (wdata), .rdata (rdata_b), .stop (stop_b), .err (err_b)
  );

  dmem_responder #(.DEPTH(1024), .ADDR_W(32), .WAIT_STATES(2)) u_c (
    .clk (clk), .rst (rst_c), .mem_w (mem_w_c), .mem_r (mem_r_c), .dwea (dwea),
    .addr (addr), .wdata (wdata), .rdata (rdata_c), .stop (stop_c), .err (err_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store_a(input logic [31:0] a, input logic [31:0] d, input logic [3:0] en);
    addr = a; wdata = d; dwea = en; mem_w_a = 1'b1;
    #1;
    check("store_no_stall", {31'd0, stop_a}, 32'd1 - 32'd1);
    tick();
    mem_w_a = 1'b0;
  endtask

  task automatic load_a(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; mem_r_a = 1'b1;
    #1;
    check({tag, "_stop_issue"}, {31'd0, stop_a}, 32'd1);
    tick();
    check({tag, "_stop_done"}, {31'd0, stop_a}, 32'd0);
    check({tag, "_data"}, rdata_a, exp);
    mem_r_a = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    mem_w_a = 1'b0; mem_r_a = 1'b0;
    mem_w_b = 1'b0; mem_r_b = 1'b0;
    mem_w_c = 1'b0; mem_r_c = 1'b0;
    addr = '0; wdata = '0; dwea = '0;
    tick();
    tick();

    // stop is forced low while reset is asserted, even with a load request
    mem_r_a = 1'b1;
    #1;
    check("stop_in_reset", {31'd0, stop_a}, 32'd0);
    tick();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; mem_r_a = 1'b0;
    #1;
    check("rst_stop", {31'd0, stop_a}, 32'd0);
    check("rst_rdata", rdata_a, 32'h0);
    check("rst_err", {31'd0, err_a}, 32'd0);
    check("rst_rdata_b", rdata_b, 32'h0);
    check("rst_err_c", {31'd0, err_c}, 32'd0);

    // word store, load on the very next cycle
    store_a(32'h10, 32'hDEADBEEF, 4'b1111);
    load_a("ld_word", 32'h10, 32'hDEADBEEF);
    check("rdata_hold", rdata_a, 32'hDEADBEEF);

    // byte store into lane 2, then back-to-back loads with different offsets
    store_a(32'h10, 32'h11223344, 4'b1111);
    store_a(32'h12, 32'h000000A5, 4'b0100);
    addr = 32'h12; mem_r_a = 1'b1;
    #1;
    check("b2b_stop1", {31'd0, stop_a}, 32'd1);
    tick();
    check("b2b_data1", rdata_a, 32'h000011A5);
    addr = 32'h10;
    tick();
    check("b2b_stop2", {31'd0, stop_a}, 32'd1);
    tick();
    check("b2b_data2", rdata_a, 32'h11A53344);
    mem_r_a = 1'b0;
    tick();
    load_a("ld_off3", 32'h13, 32'h00000011);

    // upper halfword store
    store_a(32'h12, 32'h0000BEEF, 4'b1100);
    load_a("ld_half", 32'h10, 32'hBEEF3344);

    // illegal enable: no write, sticky err through legal traffic
    store_a(32'h10, 32'hFFFFFFFF, 4'b0110);
    check("err_set", {31'd0, err_a}, 32'd1);
    load_a("ld_after_illegal", 32'h10, 32'hBEEF3344);
    store_a(32'h14, 32'h12345678, 4'b1111);
    load_a("ld_after_legal", 32'h14, 32'h12345678);
    check("err_sticky", {31'd0, err_a}, 32'd1);

    // aliasing: 0x1000 maps onto word 0
    store_a(32'h1000, 32'h0BADCAFE, 4'b1111);
    load_a("ld_alias", 32'h0, 32'h0BADCAFE);

    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    #1;
    check("err_cleared", {31'd0, err_a}, 32'd0);
    check("rdata_cleared", rdata_a, 32'h0);

    // three wait states: stop high four cycles, data in cycle five, no re-issue
    addr = 32'h20; wdata = 32'h55AA55AA; dwea = 4'b1111; mem_w_b = 1'b1;
    #1;
    check("ws3_store_no_stall", {31'd0, stop_b}, 32'd0);
    tick();
    mem_w_b = 1'b0; mem_r_b = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("ws3_stop_high", {31'd0, stop_b}, 32'd1);
      if (i == 2) check("ws3_rdata_wait", rdata_b, 32'h0);
      tick();
    end
    check("ws3_stop_done", {31'd0, stop_b}, 32'd0);
    check("ws3_data", rdata_b, 32'h55AA55AA);
    mem_r_b = 1'b0;
    tick();
    check("ws3_no_reissue", {31'd0, stop_b}, 32'd0);
    tick();
    check("ws3_hold", rdata_b, 32'h55AA55AA);

    // store and load together: store wins, no stall, err set
    addr = 32'h18; wdata = 32'hCAFEF00D; dwea = 4'b1111; mem_w_c = 1'b1; mem_r_c = 1'b1;
    #1;
    check("both_no_stall", {31'd0, stop_c}, 32'd0);
    tick();
    mem_w_c = 1'b0; mem_r_c = 1'b0;
    #1;
    check("both_err", {31'd0, err_c}, 32'd1);
    mem_r_c = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("ws2_stop_high", {31'd0, stop_c}, 32'd1);
      tick();
    end
    check("ws2_data", rdata_c, 32'hCAFEF00D);
    mem_r_c = 1'b0;
    tick();

    addr = 32'h30; wdata = 32'h13579BDF; mem_w_c = 1'b1;
    tick();
    mem_w_c = 1'b0;
    check("err_c_sticky", {31'd0, err_c}, 32'd1);

    // reset during the first wait cycle aborts the load
    mem_r_c = 1'b1;
    #1;
    check("abort_issue", {31'd0, stop_c}, 32'd1);
    tick();
    rst_c = 1'b1;
    #1;
    check("abort_stop_in_rst", {31'd0, stop_c}, 32'd0);
    tick();
    rst_c = 1'b0; mem_r_c = 1'b0;
    #1;
    check("abort_stop", {31'd0, stop_c}, 32'd0);
    check("abort_rdata", rdata_c, 32'h0);
    check("abort_err", {31'd0, err_c}, 32'd0);
    tick();
    check("abort_idle", {31'd0, stop_c}, 32'd0);
    mem_r_c = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("ram_intact_stop", {31'd0, stop_c}, 32'd1);
      tick();
    end
    check("ram_intact_data", rdata_c, 32'h13579BDF);
    mem_r_c = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the far end of the execute/memory stage's memory port. Accepts the stage's registered request (address, write data, 4-bit byte-write enables, write strobe, load strobe), performs byte-enabled stores into an internal synchronous RAM, and answers loads with read data already right-aligned to the byte address. Because the RAM is synchronous and may be configured with extra wait states, the block drives a combinational `stop` back to the pipeline to hold the stage until load data is valid.

## Interface
- `DEPTH`, 1024: RAM depth in 32-bit words; power of two.
- `ADDR_W`, 32: byte-address width.
- `WAIT_STATES`, 0: extra stall cycles per load, 0..15.
- `clk  in  1`: clock.
- `rst  in  1`: reset, synchronous, active-high.
- `mem_w  in  1`: store request; qualifies `dwea`/`wdata`.
- `mem_r  in  1`: load request; driven high by the pipeline top when the memory-stage instruction writes back from memory.
- `dwea  in  4`: byte-write enables, lane i = bits [8i+7:8i].
- `addr  in  ADDR_W`: byte address.
- `wdata  in  32`: store data, unshifted (register value).
- `rdata  out  32`: load data, word shifted right by `addr[1:0]*8`.
- `stop  out  1`: stall request to the pipeline registers.
- `err  out  1`: sticky misaligned/illegal-request flag.

## Operation
- Word index = `addr[log2(DEPTH)+1:2]`; upper address bits ignored (aliasing, wrap modulo DEPTH).
- Store write lanes: lane i written with `wdata` byte `(i - addr[1:0])` mod 4, i.e. store data shifted left by `addr[1:0]*8` to match `dwea` already shifted by the stage.
- Legal nonzero `dwea`: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other nonzero value with `mem_w`: write suppressed, `err` set.
- `mem_w` and `mem_r` both high: store performed, no load, no stall, `err` set.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: `mem_w` -> write at next edge, stay IDLE, `stop`=0. `mem_r` -> issue RAM read, latch `addr[1:0]`, load counter with `WAIT_STATES`, `stop`=1; next state WAIT if `WAIT_STATES`>0 else DONE.
  - WAIT: `stop`=1; counter decrements each cycle; at 1 -> DONE.
  - DONE: `stop`=0; `rdata` valid this cycle; next state IDLE unconditionally (request held by the pipeline is retired at this edge, so the same load is never re-issued).
- `rdata` outside DONE: holds last load result (0 after reset).
- `err` clears only on `rst`.

## Timing
- Store: zero stall; RAM updated at the edge ending the request cycle; a load to the same word issued the next cycle returns the new data.
- Load: `stop` high for `1+WAIT_STATES` cycles, data valid in cycle `2+WAIT_STATES` counted from request cycle 1.
- Back-to-back loads: DONE -> IDLE -> new load; one bubble-free handoff, no overlap.
- `stop` is combinational from state and `mem_r` (IDLE path); no combinational path from `rdata`.
- Reset values: state IDLE, `stop`=0 (when `mem_r`=0 during reset, and forced 0 while `rst`), `rdata`=0, `err`=0, counter 0. RAM contents not cleared.
- `rst` mid-load (WAIT/DONE): abort, IDLE next cycle, no write, `rdata`=0.

## Structure
- Shared definitions header: `DATA_BUS`, `MEM_ADDR_BUS`, `DMWRITE_DISABLE`, `DATA_INITIAL`, legal-enable constants, FSM state encodings (2-bit).
- One sub-module: `dmem_ram` — single-port synchronous RAM, 4 byte-write enables, registered read, parameter DEPTH.
- Top holds FSM, counter, lane rotation, alignment shifter, error logic.

## Test plan
- Store word: `mem_w`=1, `dwea`=1111, `addr`=0x10, `wdata`=0xDEADBEEF; then load 0x10 -> `stop` high 1 cycle, DONE `rdata`=0xDEADBEEF.
- Byte store/load: store `dwea`=0100, `addr`=0x12, `wdata`=0x000000A5 over word 0x11223344 -> word 0x11A53344; load `addr`=0x12 -> `rdata`=0x000011A5.
- Wait states: `WAIT_STATES`=3, load -> `stop` high exactly 4 cycles, `rdata` valid cycle 5, no re-issue after DONE.
- Illegal enable: `mem_w`, `dwea`=0110 -> word unchanged, `err`=1 sticky through later valid traffic until `rst`.
- Reset mid-load: `WAIT_STATES`=2, `rst` in first WAIT cycle -> next cycle `stop`=0, `rdata`=0, state IDLE, RAM contents intact.
- Aliasing: DEPTH=1024, store to 0x1000 then load 0x0000 -> same data.
